// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the K x K multi-channel convolution MAC.
// Defaults mirror the top-level parameter defaults.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_ACCUM  = 3'd2,
      ST_OUT    = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int DATA_WIDTH_D = 8;
   localparam int OUT_WIDTH_D  = 32;
   localparam int K_D          = 3;
   localparam int CH_D         = 4;
   localparam int PIX_W_D      = 16;

   // Counter width that stays legal when the count range collapses to one value.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int KK       = K_D * K_D;
   localparam int NW       = CH_D * KK;
   localparam int PROD_W   = 2 * DATA_WIDTH_D;
   localparam int W_IDX_W  = cnt_w(NW);
   localparam int CH_IDX_W = cnt_w(CH_D);

endpackage

// File: rtl/conv_dot_kxk.sv
// Combinational signed dot product of one K x K window with one channel's weights,
// products sign-extended to OUT_WIDTH and summed with two's-complement wrap.
module conv_dot_kxk
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int OUT_WIDTH  = OUT_WIDTH_D,
   parameter int K          = K_D
) (
   input  logic        [K*K*DATA_WIDTH-1:0] window,
   input  logic        [K*K*DATA_WIDTH-1:0] weights,
   output logic signed [OUT_WIDTH-1:0]      dot
);

   localparam int MUL_W = 2 * DATA_WIDTH;

   logic signed [MUL_W-1:0] prod [K*K];

   genvar gi;
   generate
      for (gi = 0; gi < K*K; gi++) begin : g_mul
         assign prod[gi] = $signed(window[gi*DATA_WIDTH +: DATA_WIDTH])
                         * $signed(weights[gi*DATA_WIDTH +: DATA_WIDTH]);
      end
   endgenerate

   always_comb begin
      dot = '0;
      for (int i = 0; i < K*K; i++) begin
         dot = dot + OUT_WIDTH'(prod[i]);
      end
   end

endmodule

// File: rtl/conv_kxk_mac.sv
// K x K, CH-channel convolution MAC: serial weight load, per-channel window
// accumulation, bias add and optional ReLU, with valid/ready on every side.
module conv_kxk_mac
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_D,
   parameter int OUT_WIDTH  = OUT_WIDTH_D,
   parameter int K          = K_D,
   parameter int CH         = CH_D,
   parameter int PIX_W      = PIX_W_D
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic                         done,
   input  logic [PIX_W-1:0]             num_pix,
   input  logic                         reload_w,
   input  logic                         relu_en,
   input  logic [OUT_WIDTH-1:0]         bias,
   input  logic                         weight_valid_in,
   output logic                         weight_ready_out,
   input  logic [DATA_WIDTH-1:0]        weight_data,
   input  logic                         input_valid_in,
   output logic                         input_ready_out,
   input  logic [K*K*DATA_WIDTH-1:0]    window_data,
   output logic                         out_valid_out,
   input  logic                         out_ready_in,
   output logic [OUT_WIDTH-1:0]         out_data
);

   localparam int WIN_N  = K * K;
   localparam int BANK_N = CH * WIN_N;
   localparam int WC_W   = cnt_w(BANK_N);
   localparam int CC_W   = cnt_w(CH);

   state_t state_reg, state_next;

   logic [PIX_W-1:0]            num_pix_reg;
   logic [PIX_W-1:0]            pix_cnt_reg;
   logic                        reload_w_reg;
   logic                        relu_en_reg;
   logic signed [OUT_WIDTH-1:0] bias_reg;
   logic signed [OUT_WIDTH-1:0] acc_reg;
   logic signed [OUT_WIDTH-1:0] out_reg;
   logic signed [OUT_WIDTH-1:0] dot;
   logic signed [OUT_WIDTH-1:0] sum_w;
   logic [WC_W-1:0]             w_cnt_reg;
   logic [CC_W-1:0]             ch_reg;
   logic [DATA_WIDTH-1:0]       w_bank [BANK_N];
   logic [WIN_N*DATA_WIDTH-1:0] ch_weights;

   logic w_fire, in_fire, out_fire;
   logic w_last, ch_last, pix_last;

   assign w_fire   = weight_valid_in & weight_ready_out & reload_w_reg;
   assign in_fire  = input_valid_in & input_ready_out;
   assign out_fire = out_valid_out & out_ready_in;
   assign w_last   = (w_cnt_reg == WC_W'(BANK_N - 1));
   assign ch_last  = (ch_reg == CC_W'(CH - 1));
   assign pix_last = ((pix_cnt_reg + PIX_W'(1)) == num_pix_reg);

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next       = state_reg;
      weight_ready_out = 1'b0;
      input_ready_out  = 1'b0;
      out_valid_out    = 1'b0;
      done             = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (num_pix == '0)  state_next = ST_DONE;
               else if (reload_w)  state_next = ST_LOAD_W;
               else                state_next = ST_ACCUM;
            end
         end
         ST_LOAD_W: begin
            weight_ready_out = 1'b1;
            if (w_fire && w_last) state_next = ST_ACCUM;
         end
         ST_ACCUM: begin
            input_ready_out = 1'b1;
            if (in_fire && ch_last) state_next = ST_OUT;
         end
         ST_OUT: begin
            out_valid_out = 1'b1;
            if (out_fire) state_next = pix_last ? ST_DONE : ST_ACCUM;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- weight bank ----------------
   genvar gi;
   generate
      for (gi = 0; gi < BANK_N; gi++) begin : g_bank
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               w_bank[gi] <= '0;
            else if (w_fire && (w_cnt_reg == WC_W'(gi)))
               w_bank[gi] <= weight_data;
         end
      end
      // Present the current channel's K*K weights to the dot-product unit.
      for (gi = 0; gi < WIN_N; gi++) begin : g_chw
         assign ch_weights[gi*DATA_WIDTH +: DATA_WIDTH] =
            w_bank[WC_W'(int'(ch_reg) * WIN_N + gi)];
      end
   endgenerate

   conv_dot_kxk #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .K          (K)
   ) u_dot (
      .window  (window_data),
      .weights (ch_weights),
      .dot     (dot)
   );

   assign sum_w    = acc_reg + dot + bias_reg;
   assign out_data = out_reg;

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_pix_reg  <= '0;
         pix_cnt_reg  <= '0;
         reload_w_reg <= 1'b0;
         relu_en_reg  <= 1'b0;
         bias_reg     <= '0;
         acc_reg      <= '0;
         out_reg      <= '0;
         w_cnt_reg    <= '0;
         ch_reg       <= '0;
      end else begin
         if (state_reg == ST_IDLE && start) begin
            num_pix_reg  <= num_pix;
            reload_w_reg <= reload_w;
            relu_en_reg  <= relu_en;
            bias_reg     <= bias;
            pix_cnt_reg  <= '0;
            acc_reg      <= '0;
            ch_reg       <= '0;
            w_cnt_reg    <= '0;
         end
         if (w_fire)
            w_cnt_reg <= w_last ? '0 : w_cnt_reg + WC_W'(1);
         if (in_fire) begin
            acc_reg <= acc_reg + dot;
            ch_reg  <= ch_last ? '0 : ch_reg + CC_W'(1);
            if (ch_last)
               out_reg <= (relu_en_reg && sum_w[OUT_WIDTH-1]) ? '0 : sum_w;
         end
         if (out_fire) begin
            acc_reg     <= '0;
            ch_reg      <= '0;
            pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_conv_kxk_mac.sv
// Directed bench for conv_kxk_mac (K=3, CH=4) with hand-computed results.
module tb_conv_kxk_mac;

   localparam int DW = 8;
   localparam int OW = 32;
   localparam int K  = 3;
   localparam int CH = 4;
   localparam int PW = 16;
   localparam int NW = CH * K * K;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              done;
   logic [PW-1:0]     num_pix;
   logic              reload_w;
   logic              relu_en;
   logic [OW-1:0]     bias;
   logic              weight_valid_in;
   logic              weight_ready_out;
   logic [DW-1:0]     weight_data;
   logic              input_valid_in;
   logic              input_ready_out;
   logic [K*K*DW-1:0] window_data;
   logic              out_valid_out;
   logic              out_ready_in;
   logic [OW-1:0]     out_data;

   int checks = 0;
   int errors = 0;
   int wr_hi = 0, ir_hi = 0, ov_hi = 0;
   int s_wr, s_ir, s_ov;

   always #5 clk = ~clk;

   conv_kxk_mac #(
      .DATA_WIDTH (DW), .OUT_WIDTH (OW), .K (K), .CH (CH), .PIX_W (PW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .done             (done),
      .num_pix          (num_pix),
      .reload_w         (reload_w),
      .relu_en          (relu_en),
      .bias             (bias),
      .weight_valid_in  (weight_valid_in),
      .weight_ready_out (weight_ready_out),
      .weight_data      (weight_data),
      .input_valid_in   (input_valid_in),
      .input_ready_out  (input_ready_out),
      .window_data      (window_data),
      .out_valid_out    (out_valid_out),
      .out_ready_in     (out_ready_in),
      .out_data         (out_data)
   );

   always @(posedge clk) begin
      if (weight_ready_out) wr_hi <= wr_hi + 1;
      if (input_ready_out)  ir_hi <= ir_hi + 1;
      if (out_valid_out)    ov_hi <= ov_hi + 1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic start_run(input int np, input bit rw, input bit re, input int b);
      num_pix  = PW'(np);
      reload_w = rw;
      relu_en  = re;
      bias     = OW'(b);
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      // scramble the ports so only the latched copies can be in use
      num_pix  = 16'hFFFF;
      relu_en  = ~re;
      bias     = 32'h1234_5678;
      reload_w = ~rw;
   endtask

   task automatic load_weights(input string tag, input logic [DW-1:0] w);
      int n = 0;
      int t = 0;
      weight_valid_in = 1'b1;
      weight_data     = w;
      while (n < NW && t < 200) begin
         if (weight_ready_out) n++;
         @(posedge clk); #1;
         t++;
      end
      weight_valid_in = 1'b0;
      check({tag, "_wcount"}, n, NW);
   endtask

   task automatic send_windows(input string tag, input logic [DW-1:0] v, input int cnt);
      int n = 0;
      int t = 0;
      input_valid_in = 1'b1;
      window_data    = {(K*K){v}};
      while (n < cnt && t < 200) begin
         if (input_ready_out) n++;
         @(posedge clk); #1;
         t++;
      end
      input_valid_in = 1'b0;
      check({tag, "_wincount"}, n, cnt);
   endtask

   task automatic get_result(input string tag, input int exp, input int hold);
      int t = 0;
      while (!out_valid_out && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_valid"}, int'(out_valid_out), 1);
      check({tag, "_data"}, int'(out_data), exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_hold_data"}, int'(out_data), exp);
         check({tag, "_hold_inrdy"}, int'(input_ready_out), 0);
         check({tag, "_hold_valid"}, int'(out_valid_out), 1);
      end
      out_ready_in = 1'b1;
      @(posedge clk); #1;
      out_ready_in = 1'b0;
      $display("txn %s out_data=%0d expected=%0d", tag, $signed(out_data), exp);
   endtask

   task automatic finish_run(input string tag);
      check({tag, "_done"}, int'(done), 1);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, int'(done), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_pix = '0; reload_w = 1'b0; relu_en = 1'b0;
      bias = '0; weight_valid_in = 1'b0; weight_data = '0; input_valid_in = 1'b0;
      window_data = '0; out_ready_in = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("rst_done",  int'(done), 0);
      check("rst_wrdy",  int'(weight_ready_out), 0);
      check("rst_irdy",  int'(input_ready_out), 0);
      check("rst_oval",  int'(out_valid_out), 0);
      check("rst_odata", int'(out_data), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: unit weights, windows of 2, bias -100 -> 72-100
      start_run(1, 1, 0, -100);
      load_weights("t1", 8'd1);
      send_windows("t1", 8'd2, 4);
      get_result("t1", -28, 0);
      finish_run("t1");

      // 2: retained weights, ReLU clamps; then positive bias
      s_wr = wr_hi;
      start_run(1, 0, 1, -100);
      send_windows("t2a", 8'd2, 4);
      get_result("t2a", 0, 0);
      finish_run("t2a");
      start_run(1, 0, 0, 10);
      send_windows("t2b", 8'd2, 4);
      get_result("t2b", 82, 0);
      finish_run("t2b");
      check("t2_no_wrdy", wr_hi - s_wr, 0);

      // 3: extremes
      start_run(1, 1, 0, 0);
      load_weights("t3a", 8'h80);
      send_windows("t3a", 8'h80, 4);
      get_result("t3a", 589824, 0);
      finish_run("t3a");
      start_run(1, 1, 0, 0);
      load_weights("t3b", 8'd127);
      send_windows("t3b", 8'h80, 4);
      get_result("t3b", -585216, 0);
      finish_run("t3b");

      // 4: three pixels, backpressure on the second (weights 127 retained)
      start_run(3, 0, 0, 0);
      send_windows("t4p1", 8'd1, 4);
      get_result("t4p1", 4572, 0);
      check("t4p1_not_done", int'(done), 0);
      send_windows("t4p2", 8'd2, 4);
      get_result("t4p2", 9144, 5);
      send_windows("t4p3", 8'd3, 4);
      get_result("t4p3", 13716, 0);
      finish_run("t4");

      // 5: empty run
      s_wr = wr_hi; s_ir = ir_hi; s_ov = ov_hi;
      start_run(0, 1, 0, 0);
      finish_run("t5");
      check("t5_no_wrdy", wr_hi - s_wr, 0);
      check("t5_no_irdy", ir_hi - s_ir, 0);
      check("t5_no_oval", ov_hi - s_ov, 0);

      // 6: reset mid-accumulation, then run on cleared weights
      start_run(1, 0, 0, 55);
      send_windows("t6a", 8'd5, 2);
      check("t6_pre_irdy", int'(input_ready_out), 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_irdy", int'(input_ready_out), 0);
      check("t6_rst_wrdy", int'(weight_ready_out), 0);
      check("t6_rst_oval", int'(out_valid_out), 0);
      check("t6_rst_done", int'(done), 0);
      check("t6_rst_odata", int'(out_data), 0);
      @(posedge clk); #1;
      check("t6_rst_no_done", int'(done), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      start_run(1, 0, 0, 55);
      send_windows("t6b", 8'd5, 4);
      get_result("t6b", 55, 0);
      finish_run("t6b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
